// File: rtl/ras_ckpt_pkg.sv
// Shared RAS types: op encoding, default depth and the checkpoint that travels with each branch.
// Consumed by ras_ckpt and by the decode stage through ras_op_dec.
package tcore_param;

    localparam int XLEN      = 32;
    localparam int RAS_DEPTH = 8;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        NONE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        BOTH = 2'd3
    } ras_op_e;

    typedef struct packed {
        logic [RAS_CNT_W-1:0] cnt;
        logic [RAS_PTR_W-1:0] ptr;
        logic [XLEN-1:0]      tos_data;
    } ras_ckpt_t;

    // x1 (ra) and x5 (t0) are the RISC-V link registers
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/ras_ckpt_op_dec.sv
// Combinational link-register decode of a control-flow instruction into a RAS operation.
// Also reused by the decode stage for commit-side RAS updates.
module ras_op_dec
    import tcore_param::*;
(
    input  logic       req_valid_i,
    input  logic       j_type_i,
    input  logic       jr_type_i,
    input  logic [4:0] rd_addr_i,
    input  logic [4:0] r1_addr_i,
    output ras_op_e    op_o
);

    logic w_rd_link;
    logic w_r1_link;

    assign w_rd_link = is_link(rd_addr_i);
    assign w_r1_link = is_link(r1_addr_i);

    always_comb begin
        op_o = NONE;
        if (req_valid_i) begin
            if (j_type_i) begin
                if (w_rd_link) begin
                    op_o = PUSH;
                end
            end else if (jr_type_i) begin
                case ({w_rd_link, w_r1_link})
                    2'b01:   op_o = POP;
                    2'b10:   op_o = PUSH;
                    // same link register on both sides is a call, not a coroutine swap
                    2'b11:   op_o = (rd_addr_i == r1_addr_i) ? PUSH : BOTH;
                    default: op_o = NONE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ras_ckpt.sv
// Checkpointed circular return address stack; every cycle exports {cnt, ptr, tos} for flush repair.
// Optional RAS_PERF_CNT_EN adds push/pop/overflow/underflow event counters.
module ras_ckpt
    import tcore_param::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 8,
    parameter int PTR_W     = $clog2(RAS_DEPTH),
    parameter int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              j_type_i,
    input  logic              jr_type_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [4:0]        r1_addr_i,
    input  logic [XLEN-1:0]   return_addr_i,
    input  logic              restore_i,
    input  ras_ckpt_t         restore_ckpt_i,
    output ras_ckpt_t         ckpt_o,
    output logic [XLEN-1:0]   popped_addr_o,
    output logic              predict_valid_o,
    output logic              empty_o,
    output logic              full_o
`ifdef RAS_PERF_CNT_EN
    ,
    output logic [31:0]       perf_push_o,
    output logic [31:0]       perf_pop_o,
    output logic [31:0]       perf_ovf_o,
    output logic [31:0]       perf_unf_o
`endif
);

    // The checkpoint struct is sized from the package, so the instance must agree with it
    if ((RAS_DEPTH != tcore_param::RAS_DEPTH) || (XLEN != tcore_param::XLEN)
        || (RAS_DEPTH < 2)) begin : g_cfg_err
        $error("ras_ckpt: RAS_DEPTH/XLEN must match tcore_param and RAS_DEPTH must be >= 2");
    end

    ras_op_e            w_op;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_mem [RAS_DEPTH];

    logic [PTR_W-1:0]   w_ptr_inc;
    logic [PTR_W-1:0]   w_ptr_dec;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_empty;
    logic               w_full;
    logic               w_wr_en;
    logic [PTR_W-1:0]   w_wr_idx;
    logic [XLEN-1:0]    w_wr_data;
    logic [RAS_DEPTH-1:0] w_ent_we;
    logic [XLEN-1:0]    w_tos;

    ras_op_dec u_op_dec (
        .req_valid_i (req_valid_i),
        .j_type_i    (j_type_i),
        .jr_type_i   (jr_type_i),
        .rd_addr_i   (rd_addr_i),
        .r1_addr_i   (r1_addr_i),
        .op_o        (w_op)
    );

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CNT_W'(RAS_DEPTH));
    assign w_ptr_inc = (r_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_dec = (r_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : r_ptr - PTR_W'(1);

    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_idx   = r_ptr;
        w_wr_data  = return_addr_i;
        w_ptr_next = r_ptr;
        w_cnt_next = r_cnt;
        if (restore_i) begin
            // flush repair wins; a same-cycle request belongs to the squashed path
            w_wr_en    = 1'b1;
            w_wr_idx   = restore_ckpt_i.ptr;
            w_wr_data  = restore_ckpt_i.tos_data;
            w_ptr_next = restore_ckpt_i.ptr;
            w_cnt_next = restore_ckpt_i.cnt;
        end else begin
            case (w_op)
                PUSH: begin
                    w_wr_en    = 1'b1;
                    w_wr_idx   = w_ptr_inc;
                    w_ptr_next = w_ptr_inc;
                    w_cnt_next = w_full ? r_cnt : r_cnt + CNT_W'(1);
                end
                POP: begin
                    if (!w_empty) begin
                        w_ptr_next = w_ptr_dec;
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                BOTH: begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = r_ptr;
                    if (w_empty) begin
                        w_cnt_next = CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_we
        assign w_ent_we[gi] = w_wr_en && (w_wr_idx == PTR_W'(gi));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_ptr <= w_ptr_next;
            r_cnt <= w_cnt_next;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                if (w_ent_we[i]) begin
                    r_mem[i] <= w_wr_data;
                end
            end
        end
    end

    assign w_tos           = r_mem[r_ptr];
    assign popped_addr_o   = w_tos;
    assign predict_valid_o = ((w_op == POP) || (w_op == BOTH)) && !w_empty;
    assign empty_o         = w_empty;
    assign full_o          = w_full;
    assign ckpt_o          = '{cnt: r_cnt, ptr: r_ptr, tos_data: w_tos};

`ifdef RAS_PERF_CNT_EN
    logic [31:0] r_perf_push;
    logic [31:0] r_perf_pop;
    logic [31:0] r_perf_ovf;
    logic [31:0] r_perf_unf;
    logic        w_is_push;
    logic        w_is_pop;

    assign w_is_push = (w_op == PUSH) || (w_op == BOTH);
    assign w_is_pop  = (w_op == POP)  || (w_op == BOTH);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_push <= '0;
            r_perf_pop  <= '0;
            r_perf_ovf  <= '0;
            r_perf_unf  <= '0;
        end else if (!restore_i) begin
            if (w_is_push) r_perf_push <= r_perf_push + 32'd1;
            if (w_is_pop)  r_perf_pop  <= r_perf_pop + 32'd1;
            if ((w_op == PUSH) && w_full) r_perf_ovf <= r_perf_ovf + 32'd1;
            if (w_is_pop && w_empty)      r_perf_unf <= r_perf_unf + 32'd1;
        end
    end

    assign perf_push_o = r_perf_push;
    assign perf_pop_o  = r_perf_pop;
    assign perf_ovf_o  = r_perf_ovf;
    assign perf_unf_o  = r_perf_unf;
`endif

endmodule
